// File: rtl/seven_seg_pkg.sv
// Constants and state encoding shared by the BCD converter and the seven-segment driver.
package seven_seg_pkg;

  localparam int c_DIGIT_WIDTH = 4;
  localparam int c_NUM_DIGITS  = 4;
  localparam int c_MAX_DISPLAY = 9999;

  typedef logic [1:0] state_t;

  localparam state_t c_STATE_IDLE  = 2'd0;
  localparam state_t c_STATE_SHIFT = 2'd1;
  localparam state_t c_STATE_DONE  = 2'd2;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] i_Nibble,
  output logic [3:0] o_Nibble
);

  assign o_Nibble = (i_Nibble >= 4'd5) ? (i_Nibble + 4'd3) : i_Nibble;

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: one shift per cycle, results held until the next done.
//   state | meaning
//   IDLE  | outputs held, waiting for i_Start
//   SHIFT | add-3 then shift, one input bit per cycle
//   DONE  | publish digits (or 9999 on overflow), accept a back-to-back start
module binary_to_bcd
  import seven_seg_pkg::*;
#(
  parameter int g_INPUT_WIDTH = 14
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Start,
  input  logic [g_INPUT_WIDTH-1:0] i_Binary,
  output logic                     o_Busy,
  output logic                     o_Done,
  output logic                     o_Overflow,
  output logic [3:0]               o_Digit_1,
  output logic [3:0]               o_Digit_2,
  output logic [3:0]               o_Digit_3,
  output logic [3:0]               o_Digit_4
);

  localparam int c_BCD_W     = c_NUM_DIGITS * c_DIGIT_WIDTH;
  localparam int c_SCRATCH_W = c_BCD_W + g_INPUT_WIDTH;
  localparam int c_CNT_W     = $clog2(g_INPUT_WIDTH + 1);

  state_t                 state_q, state_d;
  logic [c_CNT_W-1:0]     count_q, count_d;
  logic [c_SCRATCH_W-1:0] scratch_q, scratch_d;
  logic                   ovf_flag_q, ovf_flag_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic [c_BCD_W-1:0]     digits_q, digits_d;
  logic [c_BCD_W-1:0]     bcd_adj;
  logic                   load;

  for (genvar g = 0; g < c_NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_Nibble (scratch_q[g_INPUT_WIDTH + g*c_DIGIT_WIDTH +: c_DIGIT_WIDTH]),
      .o_Nibble (bcd_adj[g*c_DIGIT_WIDTH +: c_DIGIT_WIDTH])
    );
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    scratch_d  = scratch_q;
    ovf_flag_d = ovf_flag_q;
    busy_d     = (state_q == c_STATE_SHIFT);
    done_d     = 1'b0;
    overflow_d = overflow_q;
    digits_d   = digits_q;
    load       = i_Start && ((state_q == c_STATE_IDLE) || (state_q == c_STATE_DONE));

    case (state_q)
      c_STATE_SHIFT: begin
        scratch_d = {bcd_adj, scratch_q[g_INPUT_WIDTH-1:0]} << 1;
        count_d   = count_q - 1'b1;
        if (count_q == c_CNT_W'(1)) state_d = c_STATE_DONE;
      end
      c_STATE_DONE: begin
        done_d     = 1'b1;
        overflow_d = ovf_flag_q;
        // Overflowed values saturate the display rather than show truncated digits
        digits_d   = ovf_flag_q ? {c_NUM_DIGITS{4'd9}} : scratch_q[c_SCRATCH_W-1 -: c_BCD_W];
        state_d    = c_STATE_IDLE;
      end
      default: state_d = c_STATE_IDLE;
    endcase

    if (load) begin
      scratch_d  = {{c_BCD_W{1'b0}}, i_Binary};
      count_d    = c_CNT_W'(g_INPUT_WIDTH);
      ovf_flag_d = (32'(i_Binary) > 32'(c_MAX_DISPLAY));
      state_d    = c_STATE_SHIFT;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= c_STATE_IDLE;
      count_q    <= '0;
      scratch_q  <= '0;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      scratch_q  <= scratch_d;
      ovf_flag_q <= ovf_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      digits_q   <= digits_d;
    end
  end

  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
  assign o_Overflow = overflow_q;
  assign o_Digit_1  = digits_q[3:0];
  assign o_Digit_2  = digits_q[7:4];
  assign o_Digit_3  = digits_q[11:8];
  assign o_Digit_4  = digits_q[15:12];

endmodule

// File: tb/tb_binary_to_bcd.sv
// Directed and randomized checks of binary_to_bcd against a decimal-arithmetic reference.
module tb_binary_to_bcd;

  localparam int W = 14;

  logic         i_Clk = 1'b0;
  logic         i_Reset = 1'b1;
  logic         i_Start = 1'b0;
  logic [W-1:0] i_Binary = '0;
  logic         o_Busy, o_Done, o_Overflow;
  logic [3:0]   o_Digit_1, o_Digit_2, o_Digit_3, o_Digit_4;

  int n_total = 0;
  int n_pass  = 0;

  binary_to_bcd #(.g_INPUT_WIDTH(W)) dut (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Start    (i_Start),
    .i_Binary   (i_Binary),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Overflow (o_Overflow),
    .o_Digit_1  (o_Digit_1),
    .o_Digit_2  (o_Digit_2),
    .o_Digit_3  (o_Digit_3),
    .o_Digit_4  (o_Digit_4)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [15:0] model_digits(input int val);
    int v;
    v = (val > 9999) ? 9999 : val;
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] obs_digits();
    return {o_Digit_4, o_Digit_3, o_Digit_2, o_Digit_1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Start a conversion and observe W+1 edges; checks busy profile, done latency, digits, overflow.
  task automatic run_conv(input int val, input string tag);
    int done_edge;
    bit busy_ok;
    logic [15:0] dig;
    logic ovf;
    done_edge = 0;
    busy_ok = 1'b1;
    dig = '0;
    ovf = 1'b0;
    @(negedge i_Clk);
    i_Start = 1'b1;
    i_Binary = W'(val);
    @(posedge i_Clk);
    #1 i_Start = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge i_Clk);
      #1;
      if (k <= W && (o_Busy !== 1'b1 || o_Done !== 1'b0)) busy_ok = 1'b0;
      if (k == W + 1 && o_Busy !== 1'b0) busy_ok = 1'b0;
      if (o_Done === 1'b1 && done_edge == 0) begin
        done_edge = k;
        dig = obs_digits();
        ovf = o_Overflow;
      end
    end
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_latency"}, 32'(done_edge), 32'(W + 1));
    check({tag, "_digits"}, 32'(dig), 32'(model_digits(val)));
    check({tag, "_ovf"}, 32'(ovf), 32'(val > 9999));
  endtask

  initial begin
    int done_edges[$];
    logic [15:0] done_digits[$];
    int n_done;
    int rv;
    bit quiet;

    repeat (3) @(posedge i_Clk);
    @(negedge i_Clk);
    i_Reset = 1'b0;

    // Idle after reset: everything stays at reset values
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_Clk);
      #1;
      if ({o_Busy, o_Done, o_Overflow, obs_digits()} !== 19'd0) quiet = 1'b0;
    end
    check("reset_idle", 32'(quiet), 32'd1);

    run_conv(1234, "c1234");
    quiet = 1'b1;
    repeat (10) begin
      @(posedge i_Clk);
      #1;
      if (obs_digits() !== 16'h1234 || o_Done !== 1'b0 || o_Busy !== 1'b0) quiet = 1'b0;
    end
    check("hold_1234", 32'(quiet), 32'd1);

    run_conv(0, "c0");
    run_conv(9, "c9");
    run_conv(10, "c10");
    run_conv(9999, "c9999");
    run_conv(10000, "c10000");
    run_conv(16383, "c16383");
    run_conv(42, "c42");

    for (int i = 0; i < 12; i++) begin
      rv = (i % 3 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
      run_conv(rv, $sformatf("rand%0d_%0d", i, rv));
    end

    // Start ignored during SHIFT, back-to-back start in DONE
    @(negedge i_Clk);
    i_Start = 1'b1;
    i_Binary = W'(500);
    @(posedge i_Clk);
    #1 i_Start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge i_Clk);
      #1;
      if (o_Done === 1'b1) begin
        done_edges.push_back(k);
        done_digits.push_back(obs_digits());
      end
      if (k == 4) begin i_Start = 1'b1; i_Binary = W'(777); end
      if (k == 5) i_Start = 1'b0;
      if (k == W) begin i_Start = 1'b1; i_Binary = W'(321); end
      if (k == W + 1) i_Start = 1'b0;
    end
    check("b2b_done_count", 32'(done_edges.size()), 32'd2);
    if (done_edges.size() < 2) begin
      done_edges.push_back(-1);
      done_edges.push_back(-1);
      done_digits.push_back(16'hFFFF);
      done_digits.push_back(16'hFFFF);
    end
    check("b2b_first_edge", 32'(done_edges[0]), 32'(W + 1));
    check("b2b_first_digits", 32'(done_digits[0]), 32'(model_digits(500)));
    check("b2b_second_edge", 32'(done_edges[1]), 32'(2 * (W + 1)));
    check("b2b_second_digits", 32'(done_digits[1]), 32'(model_digits(321)));

    // Reset mid-SHIFT aborts without a done pulse
    @(negedge i_Clk);
    i_Start = 1'b1;
    i_Binary = W'(4321);
    @(posedge i_Clk);
    #1 i_Start = 1'b0;
    repeat (6) @(posedge i_Clk);
    #1 i_Reset = 1'b1;
    @(posedge i_Clk);
    #1 i_Reset = 1'b0;
    check("abort_outputs", 32'({o_Busy, o_Done, o_Overflow, obs_digits()}), 32'd0);
    n_done = 0;
    repeat (25) begin
      @(posedge i_Clk);
      #1;
      if (o_Done === 1'b1) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_hold", 32'(obs_digits()), 32'd0);

    run_conv(8, "c8_after_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
